// File: rtl/shift_frame_pkg.sv
// Shared types and sizing helpers for the shift-register frame controller.
package shift_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  // Bits needed to hold 0..n inclusive, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// Load handshake and frame-result bus between a requester and shift_frame_ctrl.
interface shift_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             abort;
  logic             result_valid;
  logic [WIDTH-1:0] result_data;
  logic             match;
  logic             aborted;

  modport master (
    output load_valid, load_data, abort,
    input  load_ready, result_valid, result_data, match, aborted
  );

  modport slave (
    input  load_valid, load_data, abort,
    output load_ready, result_valid, result_data, match, aborted
  );
endinterface

// File: rtl/shift_frame_ctrl.sv
// Serialises one word MSB-first into an external shift register, reads it back
// in parallel and reports whether the loopback matched.
module shift_frame_ctrl
  import shift_frame_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  shift_frame_ctrl_if.slave bus,
  output logic             sr_in,
  output logic             sr_shift_en,
  input  logic [WIDTH-1:0] sr_par,
  output logic             busy
);

  localparam int CNT_W    = cnt_width(WIDTH);
  localparam int GAP_W    = cnt_width(GAP);
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [WIDTH-1:0]   result_data_q, result_data_d;
  logic               match_q, match_d;
  logic               result_valid_q, result_valid_d;
  logic               aborted_q, aborted_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    word_d         = word_q;
    result_data_d  = result_data_q;
    match_d        = match_q;
    result_valid_d = 1'b0;
    aborted_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          word_d  = bus.load_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          result_data_d  = sr_par;
          match_d        = (sr_par == word_q);
          result_valid_d = 1'b1;
          gap_d          = '0;
          state_d        = (GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      gap_q          <= '0;
      word_q         <= '0;
      result_data_q  <= '0;
      match_q        <= 1'b0;
      result_valid_q <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      word_q         <= word_d;
      result_data_q  <= result_data_d;
      match_q        <= match_d;
      result_valid_q <= result_valid_d;
      aborted_q      <= aborted_d;
    end
  end

  // NOTE: outputs are gated by rst so they read 0 from the first reset cycle, before the state flops clear.
  assign sr_shift_en      = !rst && (state_q == ST_SHIFT);
  assign sr_in            = sr_shift_en && |(word_q & (MSB_MASK >> cnt_q));
  assign busy             = !rst && (state_q != ST_IDLE);
  assign bus.load_ready   = !rst && (state_q == ST_IDLE);
  assign bus.result_valid = !rst && result_valid_q;
  assign bus.aborted      = !rst && aborted_q;
  assign bus.match        = !rst && match_q;
  assign bus.result_data  = rst ? '0 : result_data_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl: two instances (GAP=1 and GAP=0) looped back through
// a bench shift register, checked every cycle against a frame-timeline model.
module tb_shift_frame_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           lv[2], ab_in[2], corrupt[2];
  logic [W-1:0]   ld[2];
  logic           sr_in_w[2], sr_en_w[2], busy_w[2];
  logic           rdy_w[2], rv_w[2], match_w[2], abo_w[2];
  logic [W-1:0]   rd_w[2], sr_q[2], sr_par[2];

  shift_frame_ctrl_if #(.WIDTH(W)) bus0 ();
  shift_frame_ctrl_if #(.WIDTH(W)) bus1 ();

  assign bus0.load_valid = lv[0];  assign bus1.load_valid = lv[1];
  assign bus0.load_data  = ld[0];  assign bus1.load_data  = ld[1];
  assign bus0.abort      = ab_in[0]; assign bus1.abort    = ab_in[1];
  assign rdy_w[0]   = bus0.load_ready;   assign rdy_w[1]   = bus1.load_ready;
  assign rv_w[0]    = bus0.result_valid; assign rv_w[1]    = bus1.result_valid;
  assign rd_w[0]    = bus0.result_data;  assign rd_w[1]    = bus1.result_data;
  assign match_w[0] = bus0.match;        assign match_w[1] = bus1.match;
  assign abo_w[0]   = bus0.aborted;      assign abo_w[1]   = bus1.aborted;
  assign sr_par[0]  = sr_q[0] ^ W'(corrupt[0]);
  assign sr_par[1]  = sr_q[1] ^ W'(corrupt[1]);

  shift_frame_ctrl #(.WIDTH(W), .GAP(1)) u0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .sr_in(sr_in_w[0]),
    .sr_shift_en(sr_en_w[0]), .sr_par(sr_par[0]), .busy(busy_w[0]));

  shift_frame_ctrl #(.WIDTH(W), .GAP(0)) u1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .sr_in(sr_in_w[1]),
    .sr_shift_en(sr_en_w[1]), .sr_par(sr_par[1]), .busy(busy_w[1]));

  // Plain shift register sitting beside each controller.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst)             sr_q[i] <= '0;
      else if (sr_en_w[i]) sr_q[i] <= {sr_q[i][W-2:0], sr_in_w[i]};
    end
  end

  int n_chk = 0, n_fail = 0;
  int stim_sent[2], stim_abort[2], dut_res[2], dut_abt[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: m_t counts cycles since acceptance (0 = idle). Frame is SHIFT for
  // t=1..W, capture at t=W+1, then GAP idle cycles.
  int           m_t[2];
  logic [W-1:0] m_word[2], m_rd[2];
  logic         m_match[2], m_rv[2], m_ab[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int g;
      g = (i == 0) ? 1 : 0;
      m_rv[i] = 1'b0;
      m_ab[i] = 1'b0;
      if (rst) begin
        m_t[i] = 0; m_rd[i] = '0; m_match[i] = 1'b0;
      end else if (m_t[i] == 0) begin
        if (lv[i]) begin m_word[i] = ld[i]; m_t[i] = 1; end
      end else if (m_t[i] <= W + 1) begin
        if (ab_in[i]) begin
          m_t[i] = 0; m_ab[i] = 1'b1;
        end else if (m_t[i] == W + 1) begin
          m_rv[i]    = 1'b1;
          m_rd[i]    = m_word[i] ^ W'(corrupt[i]);
          m_match[i] = !corrupt[i];
          m_t[i]     = (g == 0) ? 0 : m_t[i] + 1;
        end else begin
          m_t[i] = m_t[i] + 1;
        end
      end else begin
        m_t[i] = (m_t[i] >= W + 1 + g) ? 0 : m_t[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] sh;
      logic         e_shift;
      e_shift = !rst && m_t[i] >= 1 && m_t[i] <= W;
      sh      = m_word[i] >> (W - m_t[i]);
      check($sformatf("u%0d.shift_en", i), sr_en_w[i], e_shift);
      check($sformatf("u%0d.sr_in", i), sr_in_w[i], e_shift && sh[0]);
      check($sformatf("u%0d.busy", i), busy_w[i], !rst && m_t[i] != 0);
      check($sformatf("u%0d.load_ready", i), rdy_w[i], !rst && m_t[i] == 0);
      check($sformatf("u%0d.result_valid", i), rv_w[i], !rst && m_rv[i]);
      check($sformatf("u%0d.aborted", i), abo_w[i], !rst && m_ab[i]);
      check($sformatf("u%0d.result_data", i), rd_w[i], rst ? '0 : m_rd[i]);
      check($sformatf("u%0d.match", i), match_w[i], !rst && m_match[i]);
      check($sformatf("u%0d.rv_abort_excl", i), rv_w[i] & abo_w[i], 1'b0);
      if (rv_w[i])  dut_res[i]++;
      if (abo_w[i]) dut_abt[i]++;
    end
  end

  logic         tr_en[16], tr_in[16], tr_rv[16], tr_m[16], tr_rdy[16], tr_abo[16];
  logic [W-1:0] tr_rd[16];

  task automatic wait_ready(input int i);
    bit ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = rdy_w[i];
    end
    check($sformatf("u%0d.ready_timeout", i), ok, 1'b1);
  endtask

  // Present one word; returns at the start of cycle 1 of the frame.
  task automatic send(input int i, input logic [W-1:0] word, input logic with_abort);
    wait_ready(i);
    lv[i] = 1'b1; ld[i] = word; ab_in[i] = with_abort;
    @(posedge clk); #1;
    lv[i] = 1'b0; ab_in[i] = 1'b0;
    stim_sent[i]++;
  endtask

  task automatic trace(input int i, input int n, input int drop_lv_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tr_en[k] = sr_en_w[i]; tr_in[k] = sr_in_w[i]; tr_rv[k] = rv_w[i];
      tr_m[k] = match_w[i]; tr_rdy[k] = rdy_w[i]; tr_abo[k] = abo_w[i]; tr_rd[k] = rd_w[i];
      @(posedge clk); #1;
      if (k == drop_lv_at) lv[i] = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] pat;
    for (int i = 0; i < 2; i++) begin
      lv[i] = 0; ab_in[i] = 0; corrupt[i] = 0; ld[i] = '0; m_t[i] = 0;
      m_word[i] = '0; m_rd[i] = '0; m_match[i] = 0; m_rv[i] = 0; m_ab[i] = 0;
      stim_sent[i] = 0; stim_abort[i] = 0; dut_res[i] = 0; dut_abt[i] = 0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst.load_ready", rdy_w[0], 1'b0);
    check("rst.busy", busy_w[0], 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst.load_ready", rdy_w[0], 1'b1);

    // Loopback of 4'b1011.
    send(0, 4'b1011, 1'b0);
    trace(0, 8, 0);
    pat = 4'b1011;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("loop.en%0d", k), tr_en[k], 1'b1);
      check($sformatf("loop.in%0d", k), tr_in[k], pat[4-k]);
    end
    check("loop.en5", tr_en[5], 1'b0);
    check("loop.rv5", tr_rv[5], 1'b0);
    check("loop.rv6", tr_rv[6], 1'b1);
    check("loop.rv7", tr_rv[7], 1'b0);
    check("loop.rd6", tr_rd[6], 4'b1011);
    check("loop.match6", tr_m[6], 1'b1);
    check("loop.rdy6", tr_rdy[6], 1'b0);
    check("loop.rdy7", tr_rdy[7], 1'b1);

    // Corrupted readback of 4'b0110.
    corrupt[0] = 1'b1;
    send(0, 4'b0110, 1'b0);
    trace(0, 7, 0);
    corrupt[0] = 1'b0;
    check("corrupt.rv6", tr_rv[6], 1'b1);
    check("corrupt.rd6", tr_rd[6], 4'b0111);
    check("corrupt.match6", tr_m[6], 1'b0);

    // Abort in SHIFT cycle 2 of 4'b1111.
    send(0, 4'b1111, 1'b0);
    @(posedge clk); #1;
    ab_in[0] = 1'b1;
    @(posedge clk); #1;
    ab_in[0] = 1'b0;
    stim_abort[0]++;
    @(negedge clk);
    check("abort.pulse", abo_w[0], 1'b1);
    check("abort.idle", rdy_w[0], 1'b1);
    check("abort.busy", busy_w[0], 1'b0);
    check("abort.rd_held", rd_w[0], 4'b0111);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort.no_rv", rv_w[0], 1'b0);
    end

    // Back-to-back on the GAP=0 instance with load_valid held.
    wait_ready(1);
    lv[1] = 1'b1; ld[1] = 4'hA;
    @(posedge clk); #1;
    ld[1] = 4'h5;
    trace(1, 14, 6);
    pat = 4'hA;
    for (int k = 1; k <= 4; k++) check($sformatf("b2b.a_in%0d", k), tr_in[k], pat[4-k]);
    pat = 4'h5;
    for (int k = 7; k <= 10; k++) check($sformatf("b2b.b_in%0d", k), tr_in[k], pat[10-k]);
    check("b2b.rdy5", tr_rdy[5], 1'b0);
    check("b2b.rdy6", tr_rdy[6], 1'b1);
    check("b2b.rv6", tr_rv[6], 1'b1);
    check("b2b.rd6", tr_rd[6], 4'hA);
    check("b2b.match6", tr_m[6], 1'b1);
    check("b2b.en7", tr_en[7], 1'b1);
    check("b2b.rdy7", tr_rdy[7], 1'b0);
    check("b2b.rv12", tr_rv[12], 1'b1);
    check("b2b.rd12", tr_rd[12], 4'h5);
    check("b2b.match12", tr_m[12], 1'b1);
    check("b2b.rdy12", tr_rdy[12], 1'b1);

    // Random words with random aborts; abort in GAP or alongside load is ignored.
    for (int n = 0; n < 20; n++) begin
      int a, c;
      a = $urandom_range(0, 3);
      send(0, W'($urandom), a == 2);
      if (a == 0) begin
        c = $urandom_range(1, W + 1);
        repeat (c - 1) begin @(posedge clk); #1; end
        ab_in[0] = 1'b1;
        @(posedge clk); #1;
        ab_in[0] = 1'b0;
        stim_abort[0]++;
      end else if (a == 1) begin
        repeat (W + 1) begin @(posedge clk); #1; end
        ab_in[0] = 1'b1;
        @(posedge clk); #1;
        ab_in[0] = 1'b0;
      end
    end
    wait_ready(0);
    wait_ready(1);
    check("count.res_plus_abort", dut_res[0] + dut_abt[0], stim_sent[0]);
    check("count.aborts", dut_abt[0], stim_abort[0]);
    check("count.u1_results", dut_res[1], 2);

    // Reset for two cycles in the middle of a frame.
    send(0, 4'b1100, 1'b0);
    trace(0, 7, 0);
    send(0, 4'b1001, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("midrst.busy", busy_w[0], 1'b0);
      check("midrst.en", sr_en_w[0], 1'b0);
      check("midrst.rdy", rdy_w[0], 1'b0);
      check("midrst.rd", rd_w[0], 4'b0000);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst.rdy_after", rdy_w[0], 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midrst.no_pulse", rv_w[0] | abo_w[0], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_frame_ctrl.md
SHIFT_FRAME_CTRL -- requirements
Module: shift_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: shift register length and word width in bits.
REQ-002 Parameter GAP, default 1: idle cycles inserted after each frame; 0 is legal.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_valid  input  1  requester presents a word.
REQ-006 load_data  input  WIDTH  word to serialize, MSB sent first.
REQ-007 load_ready  output  1  controller can accept a word.
REQ-008 abort  input  1  cancel the frame in progress.
REQ-009 sr_in  output  1  serial bit driven to the shift register's in port.
REQ-010 sr_shift_en  output  1  shift register shifts on this clock edge when high.
REQ-011 sr_par  input  WIDTH  shift register parallel output, out[WIDTH-1:0].
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 result_valid  output  1  one-cycle pulse: result_data and match are valid.
REQ-014 result_data  output  WIDTH  sr_par value captured at the end of a frame.
REQ-015 match  output  1  result_data equals the word sent.
REQ-016 aborted  output  1  one-cycle pulse: a frame was cancelled.

Function
REQ-017 The FSM SHALL have the states IDLE, SHIFT, CAPTURE and GAP.
REQ-018 load_ready SHALL equal (state==IDLE); a word is accepted on an edge where load_valid and load_ready are both high.
REQ-019 On acceptance, the block SHALL latch load_data into an internal word register, clear the bit counter and enter SHIFT.
REQ-020 In SHIFT, sr_shift_en SHALL be 1 and sr_in SHALL be word[WIDTH-1-cnt]; cnt increments each cycle; after exactly WIDTH SHIFT cycles the FSM enters CAPTURE.
REQ-021 Outside SHIFT, sr_shift_en and sr_in SHALL be 0.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within a frame.
REQ-023 In CAPTURE (one cycle) the block SHALL register result_data<=sr_par and match<=(sr_par==word), and pulse result_valid in the following cycle.
REQ-024 After CAPTURE, the FSM SHALL enter GAP for GAP cycles and then IDLE; with GAP=0 it SHALL go directly to IDLE.
REQ-025 Timing: if the word is accepted at edge E0, SHIFT occupies cycles 1..WIDTH, CAPTURE is cycle WIDTH+1, result_valid is high in cycle WIDTH+2, and load_ready is next high in cycle WIDTH+2+GAP.
REQ-026 result_data and match SHALL hold their values until the next capture or reset.
REQ-027 abort sampled high in SHIFT or CAPTURE SHALL force the FSM to IDLE on that edge and pulse aborted for one cycle; no result_valid is produced for that frame.
REQ-028 abort in IDLE or GAP SHALL be ignored; if abort and load_valid are both high in IDLE, the word is accepted.
REQ-029 load_valid outside IDLE SHALL be ignored; the word register is not overwritten mid-frame.
REQ-030 result_valid and aborted SHALL never be high in the same cycle.

Reset
REQ-031 While rst is high: state=IDLE, cnt=0, word=0, and sr_in, sr_shift_en, busy, result_valid, result_data, match, aborted all 0; load_ready SHALL also be forced to 0.
REQ-032 Reset asserted mid-frame SHALL take effect at the next edge, with no result_valid or aborted pulse; load_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-033 Package shift_frame_pkg SHALL hold the state typedef (IDLE, SHIFT, CAPTURE, GAP) and the counter-width function/constant.
REQ-034 There SHALL be no sub-module; the shift register is instantiated alongside the controller, not inside it.

Verification
REQ-035 Reset: rst=1 for 2 cycles mid-frame -> all outputs 0 during reset; load_ready=1 in the first cycle after release; no result pulse.
REQ-036 Loopback, WIDTH=4, GAP=1, load 4'b1011 -> sr_in 1,0,1,1 in cycles 1-4 with sr_shift_en=1; result_valid in cycle 6 with result_data=4'b1011, match=1; load_ready in cycle 7.
REQ-037 Corruption: bench flips sr_par bit0 during CAPTURE for word 4'b0110 -> result_data=4'b0111, match=0.
REQ-038 Abort: abort in cycle 2 of SHIFT for word 4'b1111 -> aborted pulse, FSM in IDLE next cycle, no result_valid, previous result_data unchanged.
REQ-039 Back-to-back: load_valid held high with 4'hA then 4'h5, GAP=0 -> second word accepted in cycle 6; both results match=1; load_valid during a frame ignored.
REQ-040 Random: 20 random words with random aborts -> result count + abort count = accepted count; every non-aborted result has match=1.
